fpalu_arbiter: RTL

Round-robin scheduler that shares one fpalu floating-point add/sub unit among NREQ requesters. Accepts one operation at a time over a valid/ready handshake, holds operands stable on the fpalu inputs, waits the fixed fpalu latency, captures sum and overflow, and returns them tagged with the requester index. Sits between the requesting controllers and the single fpalu instance.

---
 rtl/fpalu_arbiter_pkg.sv | 12 +
 rtl/fpalu_rr_pick.sv | 30 +++
 rtl/fpalu_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fpalu_arbiter_pkg.sv
// Shared encodings and constants for the fpalu round-robin arbiter.
package fpalu_arbiter_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int             LAT_DEF = 2;
  localparam int             OVF_W   = 8;
  localparam logic [OVF_W-1:0] OVF_MAX = 8'd255;
endpackage

// File: rtl/fpalu_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module fpalu_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            any_o
);
  logic [IDW-1:0] idx;

  // Walk farthest-first so the candidate closest to ptr overwrites the rest.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr_i) + k) % NREQ);
      if (req_valid_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        any_o      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fpalu_arbiter.sv
// Shares one fixed-latency fpalu among NREQ requesters, one op in flight,
// result returned over a valid/ready response tagged with the requester id.
module fpalu_arbiter
  import fpalu_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1,
  parameter int LAT  = LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_s,
  output logic              rsp_ovf,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic              alu_op,
  input  logic [31:0]       alu_s,
  input  logic              alu_ovf,
  output logic              busy,
  output logic [OVF_W-1:0]  ovf_cnt
);
  localparam int CNTW = $clog2(LAT + 1);

  logic [NREQ-1:0][31:0] req_a_v, req_b_v;
  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        gnt_idx;
  logic                  gnt_any;

  state_e                state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d, tag_q, tag_d, rsp_id_q, rsp_id_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_ovf_q, rsp_ovf_d;
  logic [31:0]           rsp_s_q, rsp_s_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic                  alu_op_q, alu_op_d;
  logic [OVF_W-1:0]      ovf_q, ovf_d;

  assign req_a_v = req_a;
  assign req_b_v = req_b;

  fpalu_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid_i (req_valid),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .any_o       (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_s_d     = rsp_s_q;
    rsp_ovf_d   = rsp_ovf_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    ovf_d       = ovf_q;
    req_ready   = '0;
    case (state_q)
      S_IDLE: begin
        // Grant is combinational, so it must be forced off while reset is held.
        if (rst) req_ready = gnt;
        if (rst && gnt_any) begin
          alu_a_d  = req_a_v[gnt_idx];
          alu_b_d  = req_b_v[gnt_idx];
          alu_op_d = req_op[gnt_idx];
          tag_d    = gnt_idx;
          cnt_d    = CNTW'(LAT);
          ptr_d    = IDW'((int'(gnt_idx) + 1) % NREQ);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          rsp_s_d     = alu_s;
          rsp_ovf_d   = alu_ovf;
          rsp_id_d    = tag_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
          if (alu_ovf && ovf_q != OVF_MAX) ovf_d = ovf_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      tag_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s_q     <= '0;
      rsp_ovf_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 1'b0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_s_q     <= rsp_s_d;
      rsp_ovf_q   <= rsp_ovf_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      ovf_q       <= ovf_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign busy      = (state_q != S_IDLE);
  assign ovf_cnt   = ovf_q;
endmodule
